// File: rtl/serdes_align_pkg.sv
// Shared types and counter widths for the SerDes lane aligner.
package serdes_align_pkg;

    localparam int CNT_W  = 4;
    localparam int SLIP_W = $clog2(10);

    typedef enum logic [1:0] {
        HUNT,
        SLIP_WAIT,
        LOCKED,
        ERROR
    } lane_state_t;

endpackage

// File: rtl/serdes_lane_aligner_if.sv
// Bundle of the deserialiser-side and serialiser-side signals of all lanes.
interface serdes_lane_aligner_if #(
    parameter int WIDTH  = 4,
    parameter int NUM_CH = 2
);

    logic                    enable;
    logic [NUM_CH*WIDTH-1:0] rx_data;
    logic [NUM_CH-1:0]       rx_valid;
    logic [NUM_CH-1:0]       bitslip;
    logic [NUM_CH*WIDTH-1:0] tx_data;
    logic [NUM_CH-1:0]       tx_load;
    logic [NUM_CH-1:0]       locked;
    logic [NUM_CH-1:0]       align_err;
    logic                    all_locked;

    modport master (
        output enable, rx_data, rx_valid,
        input  bitslip, tx_data, tx_load, locked, align_err, all_locked
    );

    modport slave (
        input  enable, rx_data, rx_valid,
        output bitslip, tx_data, tx_load, locked, align_err, all_locked
    );

endinterface

// File: rtl/serdes_align_lane.sv
// One lane: bitslip-driven word alignment FSM followed by a two-stage
// payload pipe that emits (3*d + 1) mod 2^WIDTH once the lane is locked.
module serdes_align_lane
    import serdes_align_pkg::*;
#(
    parameter int               WIDTH         = 4,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = 4'h5,
    parameter int               MATCH_CNT     = 4,
    parameter int               SLIP_WAIT     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_rx_data,
    input  logic             i_rx_valid,
    output logic             o_bitslip,
    output logic [WIDTH-1:0] o_tx_data,
    output logic             o_tx_load,
    output logic             o_locked,
    output logic             o_align_err
);

    lane_state_t       r_state;
    lane_state_t       w_state_nxt;
    logic [CNT_W-1:0]  r_match_cnt;
    logic [CNT_W-1:0]  w_match_nxt;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]  w_wait_nxt;
    logic [SLIP_W-1:0] r_slip_cnt;
    logic [SLIP_W-1:0] w_slip_nxt;
    logic              r_bitslip;
    logic              w_bitslip_nxt;
    logic              w_match;
    logic              w_accept;
    logic [WIDTH-1:0]  r_d_q;
    logic              r_v1;
    logic [WIDTH-1:0]  r_tx_data;
    logic              r_tx_load;
    logic [WIDTH-1:0]  w_tx_calc;

    assign w_match  = (i_rx_data == TRAIN_PATTERN);
    assign w_accept = (r_state == LOCKED) && i_rx_valid;

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n || !i_enable) begin
            r_state     <= HUNT;
            r_match_cnt <= '0;
            r_wait_cnt  <= '0;
            r_slip_cnt  <= '0;
            r_bitslip   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_match_cnt <= w_match_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_slip_cnt  <= w_slip_nxt;
            r_bitslip   <= w_bitslip_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_state_nxt   = r_state;
        w_match_nxt   = r_match_cnt;
        w_wait_nxt    = r_wait_cnt;
        w_slip_nxt    = r_slip_cnt;
        w_bitslip_nxt = 1'b0;
        case (r_state)
            HUNT: begin
                if (i_rx_valid) begin
                    if (w_match) begin
                        if (r_match_cnt == CNT_W'(MATCH_CNT - 1)) begin
                            w_state_nxt = LOCKED;
                            w_match_nxt = '0;
                        end else begin
                            w_match_nxt = r_match_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_match_nxt = '0;
                        if (r_slip_cnt == SLIP_W'(WIDTH - 1)) begin
                            w_state_nxt = ERROR;
                        end else begin
                            w_bitslip_nxt = 1'b1;
                            w_slip_nxt    = r_slip_cnt + SLIP_W'(1);
                            w_wait_nxt    = CNT_W'(SLIP_WAIT);
                            w_state_nxt   = serdes_align_pkg::SLIP_WAIT;
                        end
                    end
                end
            end
            serdes_align_pkg::SLIP_WAIT: begin
                // Leaving on the last count lets the next edge sample a word.
                w_wait_nxt = r_wait_cnt - CNT_W'(1);
                if (r_wait_cnt == CNT_W'(1)) begin
                    w_state_nxt = HUNT;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        o_locked    = (r_state == LOCKED);
        o_align_err = (r_state == ERROR);
    end

    assign w_tx_calc = (r_d_q << 1) + WIDTH'(1) + r_d_q;

    always_ff @(posedge clk) begin
        if (!rst_n || !i_enable) begin
            r_d_q     <= '0;
            r_v1      <= 1'b0;
            r_tx_data <= '0;
            r_tx_load <= 1'b0;
        end else begin
            r_v1      <= w_accept;
            r_tx_load <= r_v1;
            if (w_accept) begin
                r_d_q <= i_rx_data;
            end
            if (r_v1) begin
                r_tx_data <= w_tx_calc;
            end
        end
    end

    assign o_bitslip = r_bitslip;
    assign o_tx_data = r_tx_data;
    assign o_tx_load = r_tx_load;

endmodule

// File: rtl/serdes_lane_aligner.sv
// Multi-lane word aligner: slices the bus into independent lanes and
// registers the all-lanes-locked status.
module serdes_lane_aligner #(
    parameter int               WIDTH         = 4,
    parameter int               NUM_CH        = 2,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = 4'h5,
    parameter int               MATCH_CNT     = 4,
    parameter int               SLIP_WAIT     = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serdes_lane_aligner_if.slave bus
);

    logic [NUM_CH-1:0]       w_bitslip;
    logic [NUM_CH*WIDTH-1:0] w_tx_data;
    logic [NUM_CH-1:0]       w_tx_load;
    logic [NUM_CH-1:0]       w_locked;
    logic [NUM_CH-1:0]       w_align_err;
    logic                    r_all_locked;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        serdes_align_lane #(
            .WIDTH         (WIDTH),
            .TRAIN_PATTERN (TRAIN_PATTERN),
            .MATCH_CNT     (MATCH_CNT),
            .SLIP_WAIT     (SLIP_WAIT)
        ) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_enable    (bus.enable),
            .i_rx_data   (bus.rx_data[g*WIDTH +: WIDTH]),
            .i_rx_valid  (bus.rx_valid[g]),
            .o_bitslip   (w_bitslip[g]),
            .o_tx_data   (w_tx_data[g*WIDTH +: WIDTH]),
            .o_tx_load   (w_tx_load[g]),
            .o_locked    (w_locked[g]),
            .o_align_err (w_align_err[g])
        );
    end

    // Gated by enable as well, so the flag drops on the same edge as the lanes.
    always_ff @(posedge clk) begin
        if (!rst_n || !bus.enable) begin
            r_all_locked <= 1'b0;
        end else begin
            r_all_locked <= &w_locked;
        end
    end

    assign bus.bitslip    = w_bitslip;
    assign bus.tx_data    = w_tx_data;
    assign bus.tx_load    = w_tx_load;
    assign bus.locked     = w_locked;
    assign bus.align_err  = w_align_err;
    assign bus.all_locked = r_all_locked;

endmodule

// File: tb/tb_serdes_lane_aligner.sv
// Bench for serdes_lane_aligner: directed tables and sequences plus random
// traffic, all compared against an event-level lane model.
module tb_serdes_lane_aligner;

    localparam int               W   = 4;
    localparam int               N   = 2;
    localparam int               MC  = 4;
    localparam int               SW  = 3;
    localparam logic [W-1:0]     TP  = 4'h5;
    localparam int               WB  = 10;
    localparam int               NB  = 4;
    localparam logic [WB-1:0]    TPB = 10'h0F1;
    localparam int               M_HUNT = 0;
    localparam int               M_LOCK = 1;
    localparam int               M_ERR  = 2;

    typedef struct {
        logic         valid;
        logic [W-1:0] data;
        logic         exp_load;
        logic [W-1:0] exp_data;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serdes_lane_aligner_if #(.WIDTH(W),  .NUM_CH(N))  bus_a ();
    serdes_lane_aligner_if #(.WIDTH(WB), .NUM_CH(NB)) bus_b ();

    serdes_lane_aligner #(
        .WIDTH(W), .NUM_CH(N), .TRAIN_PATTERN(TP), .MATCH_CNT(MC), .SLIP_WAIT(SW)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
    );

    serdes_lane_aligner #(
        .WIDTH(WB), .NUM_CH(NB), .TRAIN_PATTERN(TPB), .MATCH_CNT(MC), .SLIP_WAIT(SW)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   edge_n   = 0;
    int   phase_a [N];
    int   phase_b [NB];
    int   src_a [N];
    int   pulses;
    int   last_b;
    vec_t vt [8];

    // Lane model: state, counts, the edge from which words count again, and
    // the word accepted on the previous edge (it appears one edge later).
    int m_st [N];
    int m_match [N];
    int m_slip [N];
    int m_resume [N];
    bit m_acc_v [N];
    int m_acc_d [N];
    bit e_bs [N];
    bit e_load [N];
    int e_data [N];
    bit e_all;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int rot_left(input int x, input int w, input int k);
        int r;
        r = x;
        for (int i = 0; i < k % w; i++) r = ((r << 1) | (r >> (w - 1))) & ((1 << w) - 1);
        return r;
    endfunction

    function automatic int pick_src();
        case ($urandom_range(0, 2))
            0:       return int'(TP);
            1:       return 'hA;
            default: return int'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic drive_a(input int l, input bit v, input int word);
        bus_a.rx_valid[l]       = v;
        bus_a.rx_data[l*W +: W] = W'(rot_left(word, W, phase_a[l]));
    endtask

    task automatic model_lane(input int l, input bit en, input bit v, input int d);
        if (!en) begin
            m_st[l] = M_HUNT; m_match[l] = 0; m_slip[l] = 0; m_resume[l] = 0;
            m_acc_v[l] = 1'b0; e_bs[l] = 1'b0; e_load[l] = 1'b0; e_data[l] = 0;
            return;
        end
        e_load[l] = m_acc_v[l];
        if (m_acc_v[l]) e_data[l] = (3 * m_acc_d[l] + 1) % (1 << W);
        m_acc_v[l] = 1'b0;
        e_bs[l]    = 1'b0;
        if (m_st[l] == M_LOCK) begin
            if (v) begin
                m_acc_v[l] = 1'b1;
                m_acc_d[l] = d;
            end
        end else if (m_st[l] == M_HUNT && v && edge_n >= m_resume[l]) begin
            if (d == int'(TP)) begin
                m_match[l]++;
                if (m_match[l] == MC) begin
                    m_st[l]    = M_LOCK;
                    m_match[l] = 0;
                end
            end else begin
                m_match[l] = 0;
                if (m_slip[l] == W - 1) begin
                    m_st[l] = M_ERR;
                end else begin
                    e_bs[l]     = 1'b1;
                    m_slip[l]++;
                    m_resume[l] = edge_n + SW + 1;
                end
            end
        end
    endtask

    task automatic tick_a();
        bit             en;
        bit             prev_all;
        logic [N-1:0]   v;
        logic [N*W-1:0] d;
        en = (rst_n === 1'b1) && (bus_a.enable === 1'b1);
        v  = bus_a.rx_valid;
        d  = bus_a.rx_data;
        @(posedge clk);
        #1;
        edge_n++;
        prev_all = 1'b1;
        for (int l = 0; l < N; l++) if (m_st[l] != M_LOCK) prev_all = 1'b0;
        e_all = en && prev_all;
        for (int l = 0; l < N; l++) model_lane(l, en, v[l] === 1'b1, int'(d[l*W +: W]));
        for (int l = 0; l < N; l++) begin
            check($sformatf("bitslip[%0d]", l),   32'(bus_a.bitslip[l]),       32'(e_bs[l]));
            check($sformatf("tx_load[%0d]", l),   32'(bus_a.tx_load[l]),       32'(e_load[l]));
            check($sformatf("tx_data[%0d]", l),   32'(bus_a.tx_data[l*W +: W]), e_data[l]);
            check($sformatf("locked[%0d]", l),    32'(bus_a.locked[l]),        32'(m_st[l] == M_LOCK));
            check($sformatf("align_err[%0d]", l), 32'(bus_a.align_err[l]),     32'(m_st[l] == M_ERR));
            if (bus_a.bitslip[l] === 1'b1) phase_a[l]++;
        end
        check("all_locked", 32'(bus_a.all_locked), 32'(e_all));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        bus_a.enable = 1'b0; bus_a.rx_valid = '0; bus_a.rx_data = '0;
        bus_b.enable = 1'b0; bus_b.rx_valid = '0; bus_b.rx_data = '0;
        for (int l = 0; l < N; l++) phase_a[l] = 0;
        for (int l = 0; l < NB; l++) phase_b[l] = 0;

        // Reset with random activity: everything stays at zero.
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_a.enable = 1'($urandom_range(0, 1));
            for (int l = 0; l < N; l++) drive_a(l, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
            tick_a();
            check("reset_all_zero", 32'({bus_a.bitslip, bus_a.tx_load, bus_a.locked,
                  bus_a.align_err, bus_a.all_locked, bus_a.tx_data}), 32'd0);
        end

        // Four training words on lane 0 lock it, nothing is forwarded.
        rst_n = 1'b1;
        bus_a.enable = 1'b1;
        drive_a(1, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            drive_a(0, 1'b1, int'(TP));
            tick_a();
            check("lock_latency", 32'(bus_a.locked[0]), 32'(i == 3));
        end
        drive_a(0, 1'b0, 0);
        tick_a();
        check("no_load_after_lock", 32'(bus_a.tx_load[0]), 32'd0);

        // Lane 1 sees 4'hA; one left rotation yields 4'h5.
        pulses = 0;
        for (int i = 0; i < 40 && bus_a.locked[1] !== 1'b1; i++) begin
            drive_a(1, 1'b1, 'hA);
            tick_a();
            if (bus_a.bitslip[1] === 1'b1) pulses++;
        end
        check("rot_locked", 32'(bus_a.locked[1]), 32'd1);
        check("rot_pulses", pulses, 1);
        drive_a(1, 1'b0, 0);

        // Payload table on locked lane 0.
        vt = '{'{1'b1, 4'h0, 1'b0, 4'h0}, '{1'b1, 4'h3, 1'b1, 4'h1},
               '{1'b1, 4'hF, 1'b1, 4'hA}, '{1'b0, 4'h0, 1'b1, 4'hE},
               '{1'b0, 4'h0, 1'b0, 4'hE}, '{1'b1, 4'h7, 1'b0, 4'hE},
               '{1'b0, 4'h0, 1'b1, 4'h6}, '{1'b0, 4'h0, 1'b0, 4'h6}};
        for (int i = 0; i < 8; i++) begin
            drive_a(0, vt[i].valid, int'(vt[i].data));
            tick_a();
            check($sformatf("payload_load[%0d]", i), 32'(bus_a.tx_load[0]), 32'(vt[i].exp_load));
            check($sformatf("payload_data[%0d]", i), 32'(bus_a.tx_data[W-1:0]), 32'(vt[i].exp_data));
        end

        // Lane 0 locks on edge 10, lane 1 on edge 30 of a fresh segment.
        bus_a.enable = 1'b0;
        drive_a(0, 1'b0, 0);
        drive_a(1, 1'b0, 0);
        tick_a();
        bus_a.enable = 1'b1;
        phase_a[0] = 0;
        phase_a[1] = 0;
        for (int k = 1; k <= 32; k++) begin
            drive_a(0, k >= 7 && k <= 10, int'(TP));
            drive_a(1, k >= 27 && k <= 30, int'(TP));
            tick_a();
            if (k >= 29) check($sformatf("multi_all_locked_k%0d", k), 32'(bus_a.all_locked), 32'(k >= 31));
        end

        // Abort while streaming: no trailing load.
        for (int i = 0; i < 5; i++) begin
            drive_a(0, 1'b1, int'($urandom_range(0, 15)));
            tick_a();
        end
        bus_a.enable = 1'b0;
        drive_a(0, 1'b1, int'($urandom_range(0, 15)));
        tick_a();
        check("abort_load", 32'(bus_a.tx_load[0]), 32'd0);
        check("abort_locked", 32'(bus_a.locked[0]), 32'd0);
        bus_a.enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_a(0, 1'b1, 'h3);
            tick_a();
            check("abort_trailing_load", 32'(bus_a.tx_load[0]), 32'd0);
        end

        // Lane 1 never sees the pattern: WIDTH-1 slips, then error.
        bus_a.enable = 1'b0;
        drive_a(0, 1'b0, 0);
        tick_a();
        bus_a.enable = 1'b1;
        phase_a[1] = 0;
        pulses = 0;
        for (int i = 0; i < 40 && bus_a.align_err[1] !== 1'b1; i++) begin
            drive_a(1, 1'b1, 0);
            tick_a();
            if (bus_a.bitslip[1] === 1'b1) pulses++;
        end
        check("err_flag", 32'(bus_a.align_err[1]), 32'd1);
        check("err_pulses", pulses, W - 1);
        for (int i = 0; i < 10; i++) begin
            drive_a(1, 1'b1, 0);
            tick_a();
            if (bus_a.bitslip[1] === 1'b1) pulses++;
        end
        check("err_no_more_pulses", pulses, W - 1);
        check("err_held", 32'(bus_a.align_err[1]), 32'd1);
        bus_a.enable = 1'b0;
        tick_a();
        check("err_cleared", 32'(bus_a.align_err[1]), 32'd0);
        bus_a.enable = 1'b1;
        drive_a(1, 1'b1, 0);
        tick_a();
        check("err_rehunt_slip", 32'(bus_a.bitslip[1]), 32'd1);

        // Random traffic against the model.
        for (int l = 0; l < N; l++) src_a[l] = pick_src();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                bus_a.enable = 1'b0;
                for (int l = 0; l < N; l++) src_a[l] = pick_src();
            end else begin
                bus_a.enable = 1'b1;
            end
            for (int l = 0; l < N; l++)
                drive_a(l, $urandom_range(0, 3) != 0,
                        ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : src_a[l]);
            tick_a();
        end
        bus_a.enable = 1'b0;

        // Wide config: lane 1 starts three rotations off the training word.
        bus_b.enable = 1'b1;
        last_b = -1;
        for (int k = 1; k <= 22; k++) begin
            for (int l = 0; l < NB; l++) begin
                bus_b.rx_valid[l] = 1'b1;
                bus_b.rx_data[l*WB +: WB] = WB'(rot_left((l == 1) ? rot_left(int'(TPB), WB, WB - 3) : int'(TPB),
                                                         WB, phase_b[l]));
            end
            @(posedge clk);
            #1;
            for (int l = 0; l < NB; l++) begin
                if (bus_b.bitslip[l] === 1'b1) begin
                    phase_b[l]++;
                    if (l == 1) begin
                        if (last_b >= 0) check("wide_slip_gap", 32'((k - last_b) >= 4), 32'd1);
                        last_b = k;
                    end
                end
            end
            check($sformatf("wide_lane1_locked_k%0d", k), 32'(bus_b.locked[1]), 32'(k >= 16));
            check($sformatf("wide_all_locked_k%0d", k), 32'(bus_b.all_locked), 32'(k >= 17));
        end
        check("wide_slip_count", phase_b[1], 3);
        check("wide_other_slips", phase_b[0] + phase_b[2] + phase_b[3], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
